// File: rtl/datapath_pkg.sv
// Shared datapath types for the scalar issue stage: FU indices, FUST row
// payloads, per-row tag pairs and the per-row state encoding.
package datapath_pkg;
  localparam int FUST_ROWS  = 3;
  localparam int FUST_TAG_W = 2;

  // Tag value meaning "operand already available".
  localparam logic [FUST_TAG_W-1:0] TAG_READY = '0;

  typedef enum logic [1:0] {
    FU_ALU    = 2'd0,
    FU_LDST   = 2'd1,
    FU_BRANCH = 2'd2
  } fu_scalar_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } fust_s_row_t;

  typedef struct packed {
    fust_s_row_t           row;
    logic [FUST_TAG_W-1:0] t1;
    logic [FUST_TAG_W-1:0] t2;
  } fust_s_entry_t;

  typedef fust_s_entry_t [FUST_ROWS-1:0] fust_s_t;

  typedef enum logic [1:0] {
    FUST_EMPTY = 2'd0,
    FUST_WAIT  = 2'd1,
    FUST_RDY   = 2'd2,
    FUST_EX    = 2'd3
  } fust_state_e;

  typedef fust_state_e [FUST_ROWS-1:0] fust_state_vec_t;

  // True when a tag names the FU that just wrote back (tag k = FU k-1).
  // Compared one bit wider so FU index 3 can never alias the ready tag.
  function automatic logic tag_hit(logic [FUST_TAG_W-1:0] tag, logic [1:0] fu);
    return {1'b0, tag} == ({1'b0, fu} + 3'd1);
  endfunction
endpackage

// File: rtl/issue_fust_s_if.sv
// Dispatch <-> issue FUST interface: row writes go toward the table, table
// contents, per-row state and the write-reject pulse come back to dispatch.
interface issue_fust_s_if;
  import datapath_pkg::*;

  logic                  n_fust_s_en;
  fu_scalar_t            n_fu_s;
  fust_s_row_t           n_fust_s;
  logic [FUST_TAG_W-1:0] n_t1;
  logic [FUST_TAG_W-1:0] n_t2;
  fust_s_t               fust_s;
  fust_state_vec_t       fust_state;
  logic                  wr_err;

  modport master (
    output n_fust_s_en, n_fu_s, n_fust_s, n_t1, n_t2,
    input  fust_s, fust_state, wr_err
  );

  modport slave (
    input  n_fust_s_en, n_fu_s, n_fust_s, n_t1, n_t2,
    output fust_s, fust_state, wr_err
  );
endinterface

// File: rtl/fust_s_select.sv
// Combinational issue picker over the RDY rows.
// With ISSUE_AGE_ORDER_EN the oldest RDY row wins (ties to lowest index);
// otherwise the lowest-index RDY row wins.
module fust_s_select
  import datapath_pkg::*;
#(
  parameter int NUM_ROWS = FUST_ROWS
) (
  input  logic [NUM_ROWS-1:0]      rdy,
`ifdef ISSUE_AGE_ORDER_EN
  input  logic [NUM_ROWS-1:0][1:0] age,
`endif
  output logic                     sel_valid,
  output logic [1:0]               sel_row
);

`ifdef ISSUE_AGE_ORDER_EN
  logic [1:0] best_age;

  // Scan upward; strict compare keeps the lowest index on equal ages.
  always_comb begin
    sel_valid = 1'b0;
    sel_row   = '0;
    best_age  = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (rdy[i] && (!sel_valid || (age[i] > best_age))) begin
        sel_valid = 1'b1;
        sel_row   = 2'(i);
        best_age  = age[i];
      end
    end
  end
`else
  // Scan downward so the lowest-index RDY row is the last one kept.
  always_comb begin
    sel_valid = 1'b0;
    sel_row   = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        sel_valid = 1'b1;
        sel_row   = 2'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/issue_fust_s.sv
// Scalar functional-unit status table. One row per scalar FU holds the
// payload plus two source tags; rows wake on writeback, issue one per cycle
// and free on the FU completion pulse. wr_err is registered: it is high in
// the cycle after the edge at which a write was rejected.
// Optional feature: ISSUE_AGE_ORDER_EN (oldest-first issue selection).
module issue_fust_s
  import datapath_pkg::*;
#(
  parameter int NUM_ROWS = FUST_ROWS,
  parameter int TAG_W    = FUST_TAG_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  issue_fust_s_if.slave        disp,
  input  logic                 wb_valid,
  input  logic [1:0]           wb_fu,
  input  logic [NUM_ROWS-1:0]  fu_ex,
  input  logic                 branch_miss,
  input  logic                 ex_ready,
  output logic                 issue_valid,
  output logic [1:0]           issue_row,
  output fust_s_row_t          issue_data
);

  logic [NUM_ROWS-1:0] wr_ok;
  logic [NUM_ROWS-1:0] rdy;
  logic                sel_valid;
  logic [1:0]          sel_row;
  logic                handshake;
  logic [TAG_W-1:0]    eff_t1;
  logic [TAG_W-1:0]    eff_t2;
  logic                wr_err_q;
  logic                wr_err_d;
  fust_s_t             ent_all;
  fust_state_vec_t     st_all;

  // Incoming tags see this cycle's writeback so a new row cannot miss it.
  assign eff_t1 = (wb_valid && tag_hit(disp.n_t1, wb_fu)) ? TAG_READY : disp.n_t1;
  assign eff_t2 = (wb_valid && tag_hit(disp.n_t2, wb_fu)) ? TAG_READY : disp.n_t2;

  // A flush suppresses both the issue offer and any write in that cycle.
  assign issue_valid = sel_valid && !branch_miss;
  assign issue_row   = sel_row;
  assign handshake   = issue_valid && ex_ready;

  assign wr_err_d = disp.n_fust_s_en && !branch_miss && !(|wr_ok);

`ifdef ISSUE_AGE_ORDER_EN
  logic [NUM_ROWS-1:0][1:0] age_vec;
`endif

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    fust_state_e   state_q;
    fust_state_e   state_d;
    fust_s_entry_t ent_q;
    fust_s_entry_t ent_d;
    logic          wr_sel;

    // Writes land on an empty row, or on a row completing this very cycle.
    assign wr_sel    = disp.n_fust_s_en && !branch_miss && (disp.n_fu_s == fu_scalar_t'(gi));
    assign wr_ok[gi] = wr_sel && ((state_q == FUST_EMPTY) || ((state_q == FUST_EX) && fu_ex[gi]));
    assign rdy[gi]   = (state_q == FUST_RDY);
    assign ent_all[gi] = ent_q;
    assign st_all[gi]  = state_q;

    // Row next state: write, flush, wakeup, issue and completion.
    always_comb begin
      ent_d   = ent_q;
      state_d = state_q;
      if (wb_valid && tag_hit(ent_q.t1, wb_fu)) ent_d.t1 = TAG_READY;
      if (wb_valid && tag_hit(ent_q.t2, wb_fu)) ent_d.t2 = TAG_READY;
      if (wr_ok[gi]) begin
        ent_d.row = disp.n_fust_s;
        ent_d.t1  = eff_t1;
        ent_d.t2  = eff_t2;
        state_d   = ((eff_t1 == TAG_READY) && (eff_t2 == TAG_READY)) ? FUST_RDY : FUST_WAIT;
      end else if (branch_miss && ((state_q == FUST_WAIT) || (state_q == FUST_RDY))) begin
        state_d = FUST_EMPTY;
      end else begin
        case (state_q)
          FUST_WAIT: if ((ent_d.t1 == TAG_READY) && (ent_d.t2 == TAG_READY)) state_d = FUST_RDY;
          FUST_RDY:  if (handshake && (sel_row == 2'(gi))) state_d = FUST_EX;
          FUST_EX:   if (fu_ex[gi]) state_d = FUST_EMPTY;
          default:   state_d = state_q;
        endcase
      end
    end

    // Row state, payload and tag registers.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state_q <= FUST_EMPTY;
        ent_q   <= '0;
      end else begin
        state_q <= state_d;
        ent_q   <= ent_d;
      end
    end

`ifdef ISSUE_AGE_ORDER_EN
    logic [1:0] age_q;
    logic [1:0] age_d;

    assign age_vec[gi] = age_q;

    // Age restarts on allocation and saturates while younger rows arrive.
    always_comb begin
      age_d = age_q;
      if (wr_ok[gi]) age_d = 2'd0;
      else if ((|wr_ok) && (state_q != FUST_EMPTY) && (age_q != 2'd3)) age_d = age_q + 2'd1;
    end

    // Allocation age register.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) age_q <= 2'd0;
      else     age_q <= age_d;
    end
`endif
  end

  fust_s_select #(.NUM_ROWS(NUM_ROWS)) u_select (
    .rdy       (rdy),
`ifdef ISSUE_AGE_ORDER_EN
    .age       (age_vec),
`endif
    .sel_valid (sel_valid),
    .sel_row   (sel_row)
  );

  // Payload of the offered row.
  always_comb begin
    issue_data = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      if (sel_row == 2'(i)) issue_data = ent_all[i].row;
  end

  // Write-reject pulse register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_err_d;
  end

  assign disp.fust_s     = ent_all;
  assign disp.fust_state = st_all;
  assign disp.wr_err     = wr_err_q;

endmodule

// File: tb/tb_issue_fust_s.sv
// Directed vector bench for issue_fust_s. Each vector is held for one cycle;
// outputs are sampled 1 time unit after the following rising edge.
module tb_issue_fust_s;
  import datapath_pkg::*;

  localparam logic [1:0] E = 2'd0, W = 2'd1, R = 2'd2, X = 2'd3;
  localparam int NV = 27;

  typedef struct {
    logic       en;
    logic [1:0] fu;
    logic [1:0] t1;
    logic [1:0] t2;
    logic       wbv;
    logic [1:0] wbf;
    logic [2:0] fuex;
    logic       bm;
    logic       exr;
    logic [5:0] st;
    logic       iv;
    logic [1:0] ir;
    logic       we;
    int         src;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [1:0]  wb_fu;
  logic [2:0]  fu_ex;
  logic        branch_miss;
  logic        ex_ready;
  logic        issue_valid;
  logic [1:0]  issue_row;
  fust_s_row_t issue_data;

  int n_checks = 0;
  int n_fail   = 0;

  issue_fust_s_if dif();

  issue_fust_s dut (
    .CLK         (clk),
    .RST         (rst),
    .disp        (dif.slave),
    .wb_valid    (wb_valid),
    .wb_fu       (wb_fu),
    .fu_ex       (fu_ex),
    .branch_miss (branch_miss),
    .ex_ready    (ex_ready),
    .issue_valid (issue_valid),
    .issue_row   (issue_row),
    .issue_data  (issue_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fust_s_row_t mk_row(int k);
    fust_s_row_t r;
    r.op  = 6'(k + 1);
    r.rd  = 5'(k);
    r.rs1 = 5'(k + 1);
    r.rs2 = 5'(k + 2);
    r.imm = 16'(16'hA500 + k);
    return r;
  endfunction

  function automatic vec_t mkv(logic en, logic [1:0] fu, logic [1:0] t1, logic [1:0] t2,
                               logic wbv, logic [1:0] wbf, logic [2:0] fuex, logic bm,
                               logic exr, logic [5:0] st, logic iv, logic [1:0] ir,
                               logic we, int src);
    vec_t v;
    v.en = en; v.fu = fu; v.t1 = t1; v.t2 = t2; v.wbv = wbv; v.wbf = wbf;
    v.fuex = fuex; v.bm = bm; v.exr = exr; v.st = st; v.iv = iv; v.ir = ir;
    v.we = we; v.src = src;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(logic en, logic [1:0] fu, logic [1:0] t1, logic [1:0] t2,
                       fust_s_row_t row, logic wbv, logic [1:0] wbf, logic [2:0] fuex,
                       logic bm, logic exr);
    dif.n_fust_s_en = en;
    dif.n_fu_s      = fu_scalar_t'(fu);
    dif.n_t1        = t1;
    dif.n_t2        = t2;
    dif.n_fust_s    = row;
    wb_valid        = wbv;
    wb_fu           = wbf;
    fu_ex           = fuex;
    branch_miss     = bm;
    ex_ready        = exr;
  endtask

  vec_t       vecs [NV];
  logic [1:0] p_row;
  int         p_src;
  logic [5:0] got_st;

  initial begin
`ifdef ISSUE_AGE_ORDER_EN
    p_row = 2'd2; p_src = 8;
`else
    p_row = 2'd0; p_src = 11;
`endif
    //               en fu t1 t2 wbv wbf fuex    bm exr  state {r2,r1,r0} iv ir    we src
    vecs[0]  = mkv(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, {E, E, R}, 1, 0,     0, 0);
    vecs[1]  = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, {E, E, X}, 0, 0,     0, 0);
    vecs[2]  = mkv(0, 0, 0, 0, 0, 0, 3'b001, 0, 1, {E, E, E}, 0, 0,     0, 0);
    vecs[3]  = mkv(1, 1, 1, 0, 0, 0, 3'b000, 0, 0, {E, W, E}, 0, 0,     0, 0);
    vecs[4]  = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, {E, W, E}, 0, 0,     0, 0);
    vecs[5]  = mkv(0, 0, 0, 0, 1, 0, 3'b000, 0, 0, {E, R, E}, 1, 1,     0, 3);
    vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, {E, X, E}, 0, 0,     0, 0);
    vecs[7]  = mkv(0, 0, 0, 0, 0, 0, 3'b010, 0, 0, {E, E, E}, 0, 0,     0, 0);
    vecs[8]  = mkv(1, 2, 0, 2, 1, 1, 3'b000, 0, 0, {R, E, E}, 1, 2,     0, 8);
    vecs[9]  = mkv(1, 2, 0, 0, 0, 0, 3'b000, 0, 0, {R, E, E}, 1, 2,     1, 8);
    vecs[10] = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, {R, E, E}, 1, 2,     0, 8);
    vecs[11] = mkv(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, {R, E, R}, 1, p_row, 0, p_src);
    vecs[12] = mkv(1, 1, 0, 0, 0, 0, 3'b000, 1, 0, {E, E, E}, 0, 0,     0, 0);
    vecs[13] = mkv(1, 2, 0, 0, 0, 0, 3'b000, 0, 0, {R, E, E}, 1, 2,     0, 13);
    vecs[14] = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, {X, E, E}, 0, 0,     0, 0);
    vecs[15] = mkv(1, 0, 2, 0, 0, 0, 3'b000, 0, 0, {X, E, W}, 0, 0,     0, 0);
    vecs[16] = mkv(1, 1, 0, 0, 0, 0, 3'b000, 0, 0, {X, R, W}, 1, 1,     0, 16);
    vecs[17] = mkv(1, 0, 0, 0, 0, 0, 3'b000, 1, 1, {X, E, E}, 0, 0,     0, 0);
    vecs[18] = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, {X, E, E}, 0, 0,     0, 0);
    vecs[19] = mkv(1, 0, 3, 0, 0, 0, 3'b000, 0, 0, {X, E, W}, 0, 0,     0, 0);
    vecs[20] = mkv(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, {X, E, W}, 0, 0,     1, 0);
    vecs[21] = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, {X, E, W}, 0, 0,     0, 0);
    vecs[22] = mkv(1, 2, 0, 0, 0, 0, 3'b100, 0, 0, {R, E, W}, 1, 2,     0, 22);
    vecs[23] = mkv(0, 0, 0, 0, 1, 2, 3'b000, 0, 0, {R, E, R}, 1, 0,     0, 19);
    vecs[24] = mkv(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, {R, E, X}, 1, 2,     0, 22);
    vecs[25] = mkv(0, 0, 0, 0, 0, 0, 3'b001, 0, 1, {X, E, E}, 0, 0,     0, 0);
    vecs[26] = mkv(0, 0, 0, 0, 0, 0, 3'b100, 0, 0, {E, E, E}, 0, 0,     0, 0);

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, '0, 0, 0, 3'b000, 0, 0);
    repeat (2) @(negedge clk);
    got_st = 6'(dif.fust_state);
    chk("reset state", 64'(got_st), 64'(0));
    chk("reset issue_valid", 64'(issue_valid), 64'(0));
    chk("reset issue_row", 64'(issue_row), 64'(0));
    chk("reset issue_data", 64'(issue_data), 64'(0));
    chk("reset wr_err", 64'(dif.wr_err), 64'(0));
    chk("reset fust_s nonzero", 64'(|dif.fust_s), 64'(0));
    rst = 1'b0;

    // Table-driven vectors
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].en, vecs[k].fu, vecs[k].t1, vecs[k].t2, mk_row(k), vecs[k].wbv,
            vecs[k].wbf, vecs[k].fuex, vecs[k].bm, vecs[k].exr);
      @(posedge clk);
      #1;
      got_st = 6'(dif.fust_state);
      $display("vec %0d state=%h issue_valid=%b issue_row=%0d wr_err=%b",
               k, got_st, issue_valid, issue_row, dif.wr_err);
      chk($sformatf("v%0d state", k), 64'(got_st), 64'(vecs[k].st));
      chk($sformatf("v%0d issue_valid", k), 64'(issue_valid), 64'(vecs[k].iv));
      chk($sformatf("v%0d wr_err", k), 64'(dif.wr_err), 64'(vecs[k].we));
      if (vecs[k].iv) begin
        chk($sformatf("v%0d issue_row", k), 64'(issue_row), 64'(vecs[k].ir));
        chk($sformatf("v%0d issue_data", k), 64'(issue_data), 64'(mk_row(vecs[k].src)));
      end
      if (k == 0)
        chk("v0 fust_s row0 payload", 64'(dif.fust_s[0].row), 64'(mk_row(0)));
      if (k == 20) begin
        chk("v20 row0 t1 kept", 64'(dif.fust_s[0].t1), 64'(3));
        chk("v20 row0 payload kept", 64'(dif.fust_s[0].row), 64'(mk_row(19)));
      end
      @(negedge clk);
    end

    // Reset asserted mid-issue with a pending offer and a wr_err pulse
    drive(1, 1, 0, 0, mk_row(30), 0, 0, 3'b000, 0, 0);
    @(posedge clk);
    #1;
    $display("pre-reset write row1 issue_valid=%b issue_row=%0d", issue_valid, issue_row);
    chk("pre-reset issue_valid", 64'(issue_valid), 64'(1));
    chk("pre-reset issue_row", 64'(issue_row), 64'(1));
    @(negedge clk);
    drive(1, 1, 0, 0, mk_row(31), 0, 0, 3'b000, 0, 0);
    @(posedge clk);
    #1;
    $display("pre-reset rejected write wr_err=%b", dif.wr_err);
    chk("pre-reset wr_err", 64'(dif.wr_err), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    got_st = 6'(dif.fust_state);
    $display("async reset state=%h issue_valid=%b wr_err=%b", got_st, issue_valid, dif.wr_err);
    chk("async reset state", 64'(got_st), 64'(0));
    chk("async reset issue_valid", 64'(issue_valid), 64'(0));
    chk("async reset issue_row", 64'(issue_row), 64'(0));
    chk("async reset issue_data", 64'(issue_data), 64'(0));
    chk("async reset wr_err", 64'(dif.wr_err), 64'(0));
    chk("async reset fust_s nonzero", 64'(|dif.fust_s), 64'(0));
    @(negedge clk);
    drive(0, 0, 0, 0, '0, 0, 0, 3'b000, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_fust_s.md
# issue_fust_s

Issue-stage scalar functional-unit status table (FUST). It is the receiving end of the dispatch-to-issue interface. It accepts row writes from dispatch, holds one row per scalar FU, and clears source tags on writeback wakeup. It selects one ready row per cycle to send to execute, and returns table contents plus per-row state to dispatch for hazard checks.

## Interface
Parameters:
- NUM_ROWS, 3: scalar FU rows (ALU, LD/ST, BRANCH); row i serves FU i.
- TAG_W, 2: tag width. 0 = operand ready; k = waiting on FU k-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- n_fust_s_en  in  1  dispatch row-write strobe.
- n_fu_s  in  2  target row index (fu_scalar_t).
- n_fust_s  in  fust_s_row_t  row payload (op, rd, rs1, rs2, imm).
- n_t1, n_t2  in  TAG_W  source tags for the written row.
- wb_valid  in  1  writeback occurred this cycle.
- wb_fu  in  2  FU index that wrote back.
- fu_ex  in  NUM_ROWS  one-cycle completion pulse per FU.
- branch_miss  in  1  flush request.
- ex_ready  in  1  execute accepts an issue this cycle.
- issue_valid  out  1  a row is being offered to execute.
- issue_row  out  2  index of the offered row.
- issue_data  out  fust_s_row_t  payload of the offered row.
- fust_s  out  fust_s_t  all row payloads and tags.
- fust_state  out  NUM_ROWS x fust_state_e  per-row state.
- wr_err  out  1  write was rejected (row busy); one-cycle pulse.

## Operation
- Per-row state machine, values of fust_state_e:
  - FUST_EMPTY
  - FUST_WAIT: a tag is nonzero.
  - FUST_RDY: both tags are zero.
  - FUST_EX: issued to execute, awaiting completion.
- Transitions:
  - EMPTY: accepted write goes to RDY if both effective tags are 0, else WAIT.
  - WAIT to RDY: both tags become 0.
  - RDY to EX: row is selected and ex_ready=1.
  - EX to EMPTY: on fu_ex[i].
- Write acceptance: the write is accepted if row n_fu_s is EMPTY, or is EX with fu_ex[n_fu_s]=1 in the same cycle (complete and reallocate). Otherwise the write is dropped and wr_err pulses.
- Wakeup: when wb_valid=1, every stored tag equal to wb_fu+1 is cleared.
  - Tags written in the same cycle are compared against wb_fu as well (bypass), so a row never waits on a writeback it has already missed.
- Selection: issue_valid = any row in RDY. issue_row is the chosen row; issue_data is its payload.
  - The choice is combinational from current state.
  - Priority scheme is set under Configuration.
- Flush: branch_miss=1 sends all WAIT and RDY rows to EMPTY at the next edge.
  - EX rows are untouched.
  - A write in the same cycle is dropped; wr_err does not pulse.
  - No issue handshake completes that cycle; issue_valid is forced to 0.
- Reset: all rows EMPTY, payloads and tags 0. issue_valid=0, issue_row=0, issue_data=0, wr_err=0.

## Timing
- Write at edge N: row is visible on fust_s/fust_state after N. Earliest issue_valid is in cycle N+1 (one-cycle write-to-issue).
- Wakeup at edge N: the WAIT row reaches RDY after N and can issue in cycle N+1.
- Issue handshake completes when issue_valid and ex_ready are both high at an edge. The row becomes EX after that edge.
- If ex_ready=0, the offer persists. issue_row may change only if a higher-priority row becomes RDY.
- fu_ex and a handshake on different rows in the same cycle are independent.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- ISSUE_AGE_ORDER_EN defined:
  - Each row keeps a 2-bit allocation age, set to 0 on write.
  - Every occupied row's age increments (saturating at 3) on each accepted write to another row.
  - Selection picks the RDY row with the greatest age; ties go to the lowest index.
- Undefined: fixed priority, lowest-index RDY row wins. No age registers.

## Structure
- datapath_pkg holds fust_s_row_t, fust_s_t, fust_state_e, fu_scalar_t and the tag-ready constant 0. Add nothing local that other stages need.
- One sub-module, fust_s_select: combinational picker taking RDY vector (and ages) and producing issue_valid/issue_row.
- State, tag and payload registers stay in issue_fust_s.

## Test plan
- Write row 0 with tags 0/0 at cycle 1, ex_ready=1 -> issue_valid=1, issue_row=0 in cycle 2; fust_state[0]=FUST_EX after cycle 2; fu_ex[0] pulse -> FUST_EMPTY.
- Write row 1 with t1=1, then wb_valid=1, wb_fu=0 two cycles later -> row 1 goes WAIT, then RDY, and issues one cycle after the wakeup edge.
- Write row 2 with t2=2 in the same cycle as wb_valid=1, wb_fu=1 -> bypass applies; row 2 enters RDY directly.
- Rows 0 and 2 RDY, row 2 written first, macro defined -> issue_row=2; macro undefined -> issue_row=0.
- Rows 0 WAIT, 1 RDY, 2 EX, then branch_miss=1 -> rows 0 and 1 EMPTY, row 2 stays EX; write in the flush cycle is ignored and wr_err=0.
- Write to a row in WAIT -> wr_err=1 for one cycle and the row is unchanged. Assert RST mid-issue -> all outputs return to their reset values immediately.
